// File: rtl/pipe_addsub_pkg.sv
// Shared arithmetic definitions for the KGP-RISC execute stage:
// op encodings, status flag bit positions and op decode helpers.
package pipe_addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_e;

    localparam int FLAG_C     = 0;
    localparam int FLAG_V     = 1;
    localparam int FLAG_Z     = 2;
    localparam int FLAG_N     = 3;
    localparam int FLAG_COUNT = 4;

    function automatic logic op_inverts_b(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SBC);
    endfunction

    function automatic logic op_carry_in(input logic [1:0] op, input logic cin);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_SUB:  c = 1'b1;
            default: c = cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_addsub_slice.sv
// One combinational slice of the pipelined adder: slice sum, carry out,
// running zero flag and the carry into the slice MSB for overflow detection.
module addsub_slice
    import pipe_addsub_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a_s,
    input  logic [SW-1:0] b_s,
    input  logic          c_in,
    input  logic          zero_in,
    output logic [SW-1:0] s,
    output logic          c_out,
    output logic          zero_out,
    output logic          c_msb
);

    logic [SW:0] total;

    assign total    = {1'b0, a_s} + {1'b0, b_s} + {{SW{1'b0}}, c_in};
    assign s        = total[SW-1:0];
    assign c_out    = total[SW];
    // The top sum bit is a^b^carry_in, so the incoming carry falls out of it.
    assign c_msb    = a_s[SW-1] ^ b_s[SW-1] ^ total[SW-1];
    assign zero_out = zero_in & (total[SW-1:0] == '0);

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: one operand slice per stage with the carry rippling
// stage to stage, operand skew and result deskew registers, and a global stall.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int SW = (STAGES > 0) ? WIDTH / STAGES : WIDTH;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipe_addsub: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    logic             en;
    logic             accept;
    logic             c0;
    logic [WIDTH-1:0] b_eff;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] zero_q;
    logic              ovf_q;

    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] cy_in;
    logic [STAGES-1:0] zr_in;
    logic [STAGES-1:0] cy_out;
    logic [STAGES-1:0] zr_out;
    logic              msb_c [STAGES];
    logic [SW-1:0]     s_out [STAGES];

    // Row k holds stage k: result slices 0..k, operand slices k+1..STAGES-1.
    logic [SW-1:0] a_q   [STAGES][STAGES];
    logic [SW-1:0] b_q   [STAGES][STAGES];
    logic [SW-1:0] res_q [STAGES][STAGES];
    logic [SW-1:0] a_in   [STAGES][STAGES];
    logic [SW-1:0] b_in   [STAGES][STAGES];
    logic [SW-1:0] res_in [STAGES][STAGES];

    assign en        = !vld_q[STAGES-1] || out_ready;
    assign in_ready  = en && !rst;
    assign accept    = in_valid && in_ready;
    assign b_eff     = op_inverts_b(op) ? ~b : b;
    assign c0        = op_carry_in(op, cin);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign v_in[k]  = accept;
            assign cy_in[k] = c0;
            assign zr_in[k] = 1'b1;
            for (genvar j = 0; j < STAGES; j++) begin : g_src
                assign a_in[k][j]   = a[j*SW +: SW];
                assign b_in[k][j]   = b_eff[j*SW +: SW];
                assign res_in[k][j] = '0;
            end
        end else begin : g_body
            assign v_in[k]  = vld_q[k-1];
            assign cy_in[k] = carry_q[k-1];
            assign zr_in[k] = zero_q[k-1];
            for (genvar j = 0; j < STAGES; j++) begin : g_src
                assign a_in[k][j]   = a_q[k-1][j];
                assign b_in[k][j]   = b_q[k-1][j];
                assign res_in[k][j] = res_q[k-1][j];
            end
        end

        addsub_slice #(.SW(SW)) u_slice (
            .a_s      (a_in[k][k]),
            .b_s      (b_in[k][k]),
            .c_in     (cy_in[k]),
            .zero_in  (zr_in[k]),
            .s        (s_out[k]),
            .c_out    (cy_out[k]),
            .zero_out (zr_out[k]),
            .c_msb    (msb_c[k])
        );

        assign sum[k*SW +: SW] = res_q[STAGES-1][k];
    end

    // Data registers only load behind a valid op, so bubbles leave them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            carry_q <= '0;
            zero_q  <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                for (int j = 0; j < STAGES; j++) begin
                    a_q[k][j]   <= '0;
                    b_q[k][j]   <= '0;
                    res_q[k][j] <= '0;
                end
            end
        end else if (en) begin
            vld_q <= v_in;
            for (int k = 0; k < STAGES; k++) begin
                if (v_in[k]) begin
                    carry_q[k] <= cy_out[k];
                    zero_q[k]  <= zr_out[k];
                    for (int j = 0; j < STAGES; j++) begin
                        if (j < k) begin
                            res_q[k][j] <= res_in[k][j];
                        end else if (j == k) begin
                            res_q[k][j] <= s_out[k];
                        end else begin
                            a_q[k][j] <= a_in[k][j];
                            b_q[k][j] <= b_in[k][j];
                        end
                    end
                end
            end
            if (v_in[STAGES-1]) begin
                ovf_q <= msb_c[STAGES-1] ^ cy_out[STAGES-1];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign zero      = zero_q[STAGES-1];
    assign ovf       = ovf_q;
    assign neg       = res_q[STAGES-1][STAGES-1][SW-1];

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: depths 4, 1 and 8 share one stimulus stream and are
// compared every cycle against a word-level reference pipeline.
module tb_pipe_addsub;
    import pipe_addsub_pkg::*;

    localparam int WIDTH = 32;
    localparam int NDUT  = 3;
    localparam int MAXD  = 8;
    localparam longint SMAX = (longint'(1) <<< (WIDTH - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (WIDTH - 1));

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic             neg;
    } res_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             cin;
    logic             out_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;

    logic             rdy [NDUT];
    logic             ov  [NDUT];
    logic [WIDTH-1:0] sm  [NDUT];
    logic             co  [NDUT];
    logic             vf  [NDUT];
    logic             zr  [NDUT];
    logic             ng  [NDUT];

    int   checks = 0;
    int   errors = 0;
    int   depth [NDUT] = '{4, 1, 8};
    logic mv [NDUT][MAXD];
    res_t md [NDUT][MAXD];

    pipe_addsub #(.WIDTH(WIDTH), .STAGES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .a(a), .b(b),
        .cin(cin), .op(op), .out_valid(ov[0]), .out_ready(out_ready), .sum(sm[0]),
        .cout(co[0]), .ovf(vf[0]), .zero(zr[0]), .neg(ng[0])
    );

    pipe_addsub #(.WIDTH(WIDTH), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .a(a), .b(b),
        .cin(cin), .op(op), .out_valid(ov[1]), .out_ready(out_ready), .sum(sm[1]),
        .cout(co[1]), .ovf(vf[1]), .zero(zr[1]), .neg(ng[1])
    );

    pipe_addsub #(.WIDTH(WIDTH), .STAGES(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .a(a), .b(b),
        .cin(cin), .op(op), .out_valid(ov[2]), .out_ready(out_ready), .sum(sm[2]),
        .cout(co[2]), .ovf(vf[2]), .zero(zr[2]), .neg(ng[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t mkRes(input logic [WIDTH-1:0] s, input logic c, v, z, n);
        res_t r;
        r.sum  = s;
        r.cout = c;
        r.ovf  = v;
        r.zero = z;
        r.neg  = n;
        return r;
    endfunction

    // Whole-word arithmetic: unsigned sum for carry, signed sum for overflow.
    function automatic res_t refModel(input logic [WIDTH-1:0] x, y, input logic c, input logic [1:0] o);
        res_t             r;
        logic [WIDTH-1:0] yy;
        logic [63:0]      u;
        longint           s;
        longint           ci;
        yy = (o == OP_SUB || o == OP_SBC) ? ~y : y;
        if (o == OP_ADD)      ci = 0;
        else if (o == OP_SUB) ci = 1;
        else                  ci = c ? 1 : 0;
        u = 64'(x) + 64'(yy) + 64'(ci);
        s = longint'($signed(x)) + longint'($signed(yy)) + ci;
        r.sum  = u[WIDTH-1:0];
        r.cout = u[WIDTH];
        r.ovf  = (s > SMAX) || (s < SMIN);
        r.zero = (r.sum == '0);
        r.neg  = r.sum[WIDTH-1];
        return r;
    endfunction

    function automatic logic [FLAG_COUNT-1:0] packFlags(input logic c, v, z, n);
        logic [FLAG_COUNT-1:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        return f;
    endfunction

    task automatic compare(input string tag, input int idx, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s dut%0d observed %h expected %h", tag, idx, got, want);
        end
    endtask

    task automatic compareBit(input string tag, input int idx, input logic got, input logic want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s dut%0d observed %b expected %b", tag, idx, got, want);
        end
    endtask

    task automatic checkOutput();
        int   last;
        logic expRdy;
        for (int i = 0; i < NDUT; i++) begin
            last   = depth[i] - 1;
            expRdy = (!mv[i][last] || out_ready) && !rst;
            compareBit("in_ready", i, rdy[i], expRdy);
            compareBit("out_valid", i, ov[i], mv[i][last]);
            compare("sum", i, sm[i], md[i][last].sum);
            compareBit("cout", i, co[i], md[i][last].cout);
            compareBit("ovf", i, vf[i], md[i][last].ovf);
            compareBit("zero", i, zr[i], md[i][last].zero);
            compareBit("neg", i, ng[i], md[i][last].neg);
        end
    endtask

    // Each reference pipeline is a fixed-length queue that freezes while its output is held.
    task automatic modelAdvance();
        int last;
        for (int i = 0; i < NDUT; i++) begin
            last = depth[i] - 1;
            if (rst) begin
                for (int s = 0; s < MAXD; s++) begin
                    mv[i][s] = 1'b0;
                    md[i][s] = '0;
                end
            end else if (!mv[i][last] || out_ready) begin
                for (int s = last; s > 0; s--) begin
                    if (mv[i][s-1]) md[i][s] = md[i][s-1];
                    mv[i][s] = mv[i][s-1];
                end
                mv[i][0] = in_valid;
                if (in_valid) md[i][0] = refModel(a, b, cin, op);
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] aa, bb, input logic c,
                                 input logic [1:0] o, input logic ordy, input logic r);
        in_valid  = v;
        a         = aa;
        b         = bb;
        cin       = c;
        op        = o;
        out_ready = ordy;
        rst       = r;
        #1;
        checkOutput();
        modelAdvance();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, $urandom, $urandom, 1'($urandom), 2'($urandom), 1'b1, 1'b0);
        end
    endtask

    task automatic randomOp(input logic ordy);
        applyStimulus(1'b1, $urandom, $urandom, 1'($urandom), 2'($urandom), ordy, 1'b0);
    endtask

    task automatic checkDirected(input string tag, input res_t want);
        compareBit({tag, "_valid"}, 0, ov[0], 1'b1);
        compare({tag, "_sum"}, 0, sm[0], want.sum);
        compare({tag, "_flags"}, 0, WIDTH'(packFlags(co[0], vf[0], zr[0], ng[0])),
                WIDTH'(packFlags(want.cout, want.ovf, want.zero, want.neg)));
    endtask

    task automatic checkCleared(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            compareBit({tag, "_valid"}, i, ov[i], 1'b0);
            compare({tag, "_sum"}, i, sm[i], '0);
            compare({tag, "_flags"}, i, WIDTH'(packFlags(co[i], vf[i], zr[i], ng[i])), '0);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] pa;
        logic [WIDTH-1:0] pb;
        logic             pc;
        logic [1:0]       po;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op        = OP_ADD;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        modelAdvance();

        applyStimulus(1'b0, '0, '0, 1'b0, OP_ADD, 1'b1, 1'b1);
        checkCleared("reset");

        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 1'b1, 1'b0);
        idle(3);
        checkDirected("add_wrap", mkRes(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0));

        applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, OP_ADD, 1'b1, 1'b0);
        idle(3);
        checkDirected("add_ovf", mkRes(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1));

        applyStimulus(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, OP_SUB, 1'b1, 1'b0);
        idle(3);
        checkDirected("sub_borrow", mkRes(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1));

        applyStimulus(1'b1, 32'h0000_FFFF, 32'h0000_0000, 1'b1, OP_ADC, 1'b1, 1'b0);
        idle(3);
        checkDirected("adc_cross", mkRes(32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0));

        applyStimulus(1'b1, 32'h0000_0010, 32'h0000_0001, 1'b0, OP_SBC, 1'b1, 1'b0);
        idle(3);
        checkDirected("sbc", mkRes(32'h0000_000E, 1'b1, 1'b0, 1'b0, 1'b0));
        idle(8);

        $display("[TB] streaming 8 back-to-back ops");
        for (int i = 0; i < 8; i++) randomOp(1'b1);
        idle(10);

        $display("[TB] backpressure");
        pa = $urandom;
        pb = $urandom;
        pc = 1'($urandom);
        po = 2'($urandom);
        applyStimulus(1'b1, pa, pb, pc, po, 1'b1, 1'b0);
        randomOp(1'b1);
        randomOp(1'b1);
        applyStimulus(1'b1, 32'h1234_5678, 32'h0000_1111, 1'b0, OP_ADD, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h1234_5678, 32'h0000_1111, 1'b0, OP_ADD, 1'b0, 1'b0);
            checkDirected("stall_hold", refModel(pa, pb, pc, po));
            compareBit("stall_in_ready", 0, rdy[0], 1'b0);
        end
        idle(12);

        $display("[TB] reset mid-flight");
        for (int i = 0; i < 3; i++) randomOp(1'b1);
        applyStimulus(1'b1, $urandom, $urandom, 1'b0, OP_ADD, 1'b1, 1'b1);
        checkCleared("rst_mid");
        idle(10);
        checkCleared("rst_after");
        applyStimulus(1'b1, 32'h0000_00FF, 32'h0000_0F01, 1'b0, OP_ADD, 1'b1, 1'b0);
        idle(3);
        checkDirected("post_rst", mkRes(32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0));
        idle(8);

        $display("[TB] random traffic with stalls and resets");
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom), $urandom, $urandom, 1'($urandom), 2'($urandom),
                          ($urandom_range(3, 0) != 0), ($urandom_range(31, 0) == 0));
        end
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
